pwm_dac_stage: RTL

PWM_DAC_STAGE -- requirements
Module: pwm_dac_stage

---
 rtl/pwm_dac_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/pwm_dac_stage.sv
// pwm_dac_stage: 8-bit PWM DAC fed by a valid/ready sample stream through a one-deep holding register.
// Optional saturating underrun counter is built when `PWM_DAC_STAGE_UNDERRUN_CNT_EN is defined.
module pwm_dac_stage #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [DIV_W-1:0] div,
    output logic             pwm_out,
    output logic             period_done,
    output logic             underrun,
    output logic [7:0]       underrun_cnt
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] presc;
    logic [7:0]       pwm_cnt;
    logic [7:0]       duty;
    logic [7:0]       hold;
    logic             hold_empty;

    logic             accept;
    logic             tick;
    logic             period_end;

    // Comparing with >= lets a lowered div take effect at once instead of waiting for a wrap.
    always_comb begin
        accept     = sample_valid && hold_empty;
        tick       = (state == RUN) && (presc >= div);
        period_end = tick && (pwm_cnt == 8'd255);
    end

    assign sample_ready = hold_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            presc       <= '0;
            pwm_cnt     <= 8'd0;
            duty        <= 8'd0;
            // NOTE: hold data is reset as well, so no X can ever be copied into duty.
            hold        <= 8'd0;
            hold_empty  <= 1'b1;
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here; every read sees pre-edge values.
            period_done <= 1'b0;
            underrun    <= 1'b0;
            case (state)
                IDLE: begin
                    presc   <= '0;
                    pwm_cnt <= 8'd0;
                    pwm_out <= 1'b0;
                    if (accept) begin
                        duty  <= sample_in;
                        state <= RUN;
                    end
                end
                RUN: begin
                    presc   <= tick ? '0 : presc + DIV_W'(1);
                    pwm_out <= (pwm_cnt < duty);
                    if (tick) begin
                        pwm_cnt <= pwm_cnt + 8'd1;
                    end
                    if (period_end) begin
                        period_done <= 1'b1;
                        if (hold_empty) begin
                            underrun <= 1'b1;
                        end else begin
                            duty <= hold;
                        end
                    end
                    // An accept needs hold_empty, so it never coincides with a full reload.
                    if (accept) begin
                        hold       <= sample_in;
                        hold_empty <= 1'b0;
                    end else if (period_end && !hold_empty) begin
                        hold_empty <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PWM_DAC_STAGE_UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_cnt <= 8'd0;
        end else if (period_end && hold_empty && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end
`else
    assign underrun_cnt = 8'd0;
`endif

    a_underrun_at_period_end : assert property (
        @(posedge clk) disable iff (rst) underrun |-> period_done
    );

    a_hold_only_in_run : assert property (
        @(posedge clk) disable iff (rst) !sample_ready |-> (state == RUN)
    );

endmodule
